// File: rtl/drum_div_pkg.sv
// Shared types and width helpers for the DRUM approximate divider.
package drum_div_pkg;

   typedef enum logic [1:0] {
      IDLE,
      NORM,
      DIV,
      DONE
   } state_e;

   function automatic int cntWidth(input int k);
      return (2 * k > 1) ? $clog2(2 * k) : 1;
   endfunction

   // Wide enough for sa - sb - K over its full range, plus a sign bit.
   function automatic int expWidth(input int n, input int m, input int k);
      return $clog2(n + m + k + 1) + 1;
   endfunction

endpackage

// File: rtl/drum_lod_trunc.sv
// Leading-one detect and K-bit truncation with the kept LSB forced high.
module drum_lod_trunc #(
   parameter int W = 8,
   parameter int K = 4
) (
   input  logic [W-1:0]         x_i,
   output logic [K-1:0]         xt_o,
   output logic [$clog2(W)-1:0] sft_o
);

   localparam int LW = $clog2(W);

   logic [LW-1:0] lead;

   always_comb begin
      lead = '0;
      for (int i = 0; i < W; i++) begin
         if (x_i[i]) lead = LW'(i);
      end
   end

   // Small operands (leading one below K) pass through untouched and unshifted.
   always_comb begin
      xt_o  = x_i[K-1:0];
      sft_o = '0;
      if (int'(lead) >= K) begin
         sft_o = lead - LW'(K - 1);
         xt_o  = K'(x_i >> sft_o) | K'(1);
      end
   end

endmodule

// File: rtl/drum_div.sv
// DRUM approximate divider: truncate operands, restoring divide, rescale by exponents.
module drum_div
   import drum_div_pkg::*;
#(
   parameter int N = 8,
   parameter int M = 4,
   parameter int K = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] a,
   input  logic [M-1:0] b,
   output logic         busy,
   output logic         valid,
   output logic [N-1:0] q,
   output logic         div_by_zero
);

   localparam int CW  = cntWidth(K);
   localparam int EW  = expWidth(N, M, K);
   localparam int SW  = N + 2 * K;
   localparam int SAW = $clog2(N);
   localparam int SBW = $clog2(M);

   state_e               stateQ, stateD;
   logic                 accept;
   logic [N-1:0]         aQ;
   logic [M-1:0]         bQ;
   logic [K-1:0]         at, bt;
   logic [SAW-1:0]       sa;
   logic [SBW-1:0]       sb;
   logic [K-1:0]         btQ, remQ;
   logic [2*K-1:0]       quoQ;
   logic [CW-1:0]        cntQ;
   logic                 divDoneQ;
   logic signed [EW-1:0] expQ;
   logic [N-1:0]         qQ;
   logic                 dbzQ;
   logic [K:0]           remShift;
   logic                 quoBit;
   logic [K-1:0]         remNext;
   logic [SW-1:0]        quoWide, scaled;
   logic [EW-1:0]        negExp;
   logic                 overflow;
   logic [N-1:0]         qScaled;

   drum_lod_trunc #(.W(N), .K(K)) uLodA (
      .x_i   (aQ),
      .xt_o  (at),
      .sft_o (sa)
   );

   drum_lod_trunc #(.W(M), .K(K)) uLodB (
      .x_i   (bQ),
      .xt_o  (bt),
      .sft_o (sb)
   );

   always_comb begin
      stateD = stateQ;
      accept = 1'b0;
      case (stateQ)
         IDLE: begin
            if (start) begin
               stateD = NORM;
               accept = 1'b1;
            end
         end
         NORM: stateD = DIV;
         DIV: begin
            if (divDoneQ) stateD = DONE;
         end
         DONE: begin
            stateD = IDLE;
            if (start) begin
               stateD = NORM;
               accept = 1'b1;
            end
         end
         default: stateD = IDLE;
      endcase
   end

   // One restoring step: bring down the next dividend bit, subtract if it fits.
   always_comb begin
      remShift = {remQ, quoQ[2*K-1]};
      quoBit   = (remShift >= {1'b0, btQ});
      remNext  = quoBit ? K'(remShift - {1'b0, btQ}) : remShift[K-1:0];
   end

   always_comb begin
      quoWide  = {{N{1'b0}}, quoQ};
      negExp   = EW'(-expQ);
      scaled   = expQ[EW-1] ? (quoWide >> negExp) : (quoWide << $unsigned(expQ));
      overflow = |scaled[SW-1:N];
      qScaled  = (overflow || (bQ == '0)) ? {N{1'b1}} : scaled[N-1:0];
   end

   // Divider registers load in NORM, iterate in DIV, and the scaled result lands on DONE entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         stateQ   <= IDLE;
         aQ       <= '0;
         bQ       <= '0;
         btQ      <= '0;
         remQ     <= '0;
         quoQ     <= '0;
         cntQ     <= '0;
         divDoneQ <= 1'b0;
         expQ     <= '0;
         qQ       <= '0;
         dbzQ     <= 1'b0;
      end else begin
         stateQ <= stateD;
         if (accept) begin
            aQ <= a;
            bQ <= b;
         end
         case (stateQ)
            NORM: begin
               btQ      <= bt;
               remQ     <= '0;
               quoQ     <= {at, K'(0)};
               cntQ     <= '0;
               divDoneQ <= 1'b0;
               expQ     <= EW'(sa) - EW'(sb) - EW'(K);
            end
            DIV: begin
               if (!divDoneQ) begin
                  remQ <= remNext;
                  quoQ <= {quoQ[2*K-2:0], quoBit};
                  cntQ <= cntQ + CW'(1);
                  if (cntQ == CW'(2 * K - 1)) divDoneQ <= 1'b1;
               end else begin
                  qQ   <= qScaled;
                  dbzQ <= (bQ == '0);
               end
            end
            default: ;
         endcase
      end
   end

   assign busy        = (stateQ == NORM) || (stateQ == DIV);
   assign valid       = (stateQ == DONE);
   assign q           = qQ;
   assign div_by_zero = dbzQ;

endmodule

// File: tb/tb_drum_div.sv
// Self-checking bench for drum_div: directed cases plus a full operand sweep.
module tb_drum_div;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] a;
   logic [3:0] b;
   logic       busy;
   logic       valid;
   logic [7:0] q;
   logic       div_by_zero;

   int checkCount = 0;
   int errorCount = 0;

   always #5 clk = ~clk;

   drum_div #(.N(8), .M(4), .K(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .a           (a),
      .b           (b),
      .busy        (busy),
      .valid       (valid),
      .q           (q),
      .div_by_zero (div_by_zero)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issues one operation from IDLE or DONE and waits (bounded) for valid.
   task automatic applyStimulus(input logic [7:0] aIn, input logic [3:0] bIn,
                                output int qOut, output int dbzOut, output int latency);
      start = 1'b1;
      a     = aIn;
      b     = bIn;
      tick();
      start = 1'b0;
      a     = 8'($urandom);
      b     = 4'($urandom);
      latency = -1;
      for (int i = 1; i <= 40; i++) begin
         tick();
         if (valid) begin
            latency = i;
            break;
         end
      end
      qOut   = int'(q);
      dbzOut = int'(div_by_zero);
   endtask

   function automatic void truncOp(input int x, input int w, output int xt, output int s);
      int l;
      l = -1;
      for (int i = w - 1; i >= 0; i--) begin
         if (l < 0 && ((x >> i) & 1) != 0) l = i;
      end
      if (l >= 4) begin
         s  = l - 3;
         xt = (x >> s) | 1;
      end else begin
         s  = 0;
         xt = x;
      end
   endfunction

   function automatic int refQ(input int av, input int bv);
      int at, bt, sa, sb, q0, e, r;
      if (bv == 0) return 255;
      truncOp(av, 8, at, sa);
      truncOp(bv, 4, bt, sb);
      q0 = (at * 16) / bt;
      e  = sa - sb - 4;
      r  = (e >= 0) ? (q0 << e) : (q0 >> (-e));
      if (r > 255) r = 255;
      return r;
   endfunction

   initial begin
      int qv, dv, lat, lat2, busyHigh, validSeen;

      rst   = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      tick();
      tick();
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_valid", valid, 0);
      checkOutput("reset_q", q, 0);
      checkOutput("reset_dbz", div_by_zero, 0);
      rst = 1'b0;
      tick();

      // 6/2 with busy tracked edge by edge
      start = 1'b1;
      a     = 8'd6;
      b     = 4'd2;
      tick();
      start    = 1'b0;
      busyHigh = 0;
      lat      = -1;
      for (int i = 1; i <= 40; i++) begin
         tick();
         if (valid) begin
            lat = i;
            break;
         end
         if (busy) busyHigh++;
      end
      checkOutput("t1_latency", lat, 10);
      checkOutput("t1_busy_edges", busyHigh, 9);
      checkOutput("t1_busy_in_done", busy, 0);
      checkOutput("t1_q", q, 3);
      checkOutput("t1_dbz", div_by_zero, 0);
      tick();
      checkOutput("t1_valid_one_cycle", valid, 0);
      checkOutput("t1_q_held", q, 3);

      applyStimulus(8'd200, 4'd3, qv, dv, lat);
      checkOutput("t2_200_3_q", qv, 69);
      checkOutput("t2_200_3_lat", lat, 10);
      applyStimulus(8'd255, 4'd15, qv, dv, lat);
      checkOutput("t2_255_15_q", qv, 16);

      applyStimulus(8'd13, 4'd0, qv, dv, lat);
      checkOutput("t3_dbz_q", qv, 255);
      checkOutput("t3_dbz_flag", dv, 1);
      checkOutput("t3_dbz_lat", lat, 10);

      // start held high across two back-to-back operations
      tick();
      tick();
      start = 1'b1;
      a     = 8'd6;
      b     = 4'd2;
      tick();
      a   = 8'd9;
      b   = 4'd3;
      lat = -1;
      for (int i = 1; i <= 40; i++) begin
         tick();
         if (valid) begin
            lat = i;
            break;
         end
      end
      checkOutput("t4_first_lat", lat, 10);
      checkOutput("t4_first_q", q, 3);
      tick();
      checkOutput("t4_accept_in_done", busy, 1);
      start = 1'b0;
      lat2  = -1;
      for (int i = 1; i <= 40; i++) begin
         tick();
         if (valid) begin
            lat2 = i;
            break;
         end
      end
      checkOutput("t4_second_lat", lat2, 10);
      checkOutput("t4_second_q", q, 3);

      // reset in the fourth DIV cycle aborts the operation
      tick();
      start = 1'b1;
      a     = 8'd200;
      b     = 4'd3;
      tick();
      start = 1'b0;
      repeat (4) tick();
      checkOutput("t5_busy_before_rst", busy, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkOutput("t5_busy", busy, 0);
      checkOutput("t5_valid", valid, 0);
      checkOutput("t5_q", q, 0);
      checkOutput("t5_dbz", div_by_zero, 0);
      validSeen = 0;
      repeat (15) begin
         tick();
         if (valid) validSeen++;
      end
      checkOutput("t5_no_valid_after_abort", validSeen, 0);
      applyStimulus(8'd12, 4'd4, qv, dv, lat);
      checkOutput("t5_after_q", qv, 3);
      checkOutput("t5_after_lat", lat, 10);

      // reset and start on the same edge: nothing accepted
      tick();
      rst   = 1'b1;
      start = 1'b1;
      tick();
      rst   = 1'b0;
      start = 1'b0;
      checkOutput("rst_start_busy", busy, 0);
      tick();
      checkOutput("rst_start_busy_next", busy, 0);

      for (int ai = 0; ai < 256; ai++) begin
         for (int bi = 0; bi < 16; bi++) begin
            applyStimulus(8'(ai), 4'(bi), qv, dv, lat);
            checkOutput($sformatf("sweep_q a=%0d b=%0d", ai, bi), qv, refQ(ai, bi));
            checkOutput($sformatf("sweep_dbz a=%0d b=%0d", ai, bi), dv, (bi == 0) ? 1 : 0);
            checkOutput($sformatf("sweep_lat a=%0d b=%0d", ai, bi), lat, 10);
            if (ai < 16 && bi != 0)
               checkOutput($sformatf("sweep_exact a=%0d b=%0d", ai, bi), qv, ai / bi);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
